// File: rtl/tlc_timed_if.sv
// Lamp, sensor and status bundle for the highway/country-road controller.
// slave = controller side, master = board or bench side.
interface tlc_timed_if;
  logic       x;
  logic       flash;
  logic [1:0] hwy;
  logic [1:0] cntry;
  logic       tick;
  logic [2:0] state_o;

  modport master (
    output x,
    output flash,
    input  hwy,
    input  cntry,
    input  tick,
    input  state_o
  );

  modport slave (
    input  x,
    input  flash,
    output hwy,
    output cntry,
    output tick,
    output state_o
  );
endinterface

// File: rtl/tlc_timed.sv
// Highway/country-road traffic light controller with built-in tick divider,
// configurable green/yellow/all-red timing and a flashing night mode.
module tlc_timed #(
  parameter int DIV       = 50_000_000,
  parameter int TW        = 8,
  parameter int HWY_MIN   = 10,
  parameter int CNTRY_MAX = 8,
  parameter int YEL       = 3,
  parameter int ALLRED    = 1
) (
  input  logic        clk,
  input  logic        clr,
  tlc_timed_if.slave  io
);

  typedef enum logic [2:0] {
    HG    = 3'd0,
    HY    = 3'd1,
    AR1   = 3'd2,
    CG    = 3'd3,
    CY    = 3'd4,
    AR2   = 3'd5,
    FLASH = 3'd6
  } state_e;

  localparam logic [1:0] L_RED  = 2'b00;
  localparam logic [1:0] L_YEL  = 2'b01;
  localparam logic [1:0] L_GRN  = 2'b10;
  localparam logic [1:0] L_DARK = 2'b11;

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_END = DW'(DIV - 1);

  localparam logic [TW:0] HMIN_L = (TW+1)'(HWY_MIN);
  localparam logic [TW:0] CMAX_L = (TW+1)'(CNTRY_MAX);
  localparam logic [TW:0] YEL_L  = (TW+1)'(YEL);
  localparam logic [TW:0] AR_L   = (TW+1)'(ALLRED);

  logic [DW-1:0] div_q, div_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [TW:0]   el;
  state_e        state_q, state_d;
  logic          ph_q, ph_d;
  logic          tick;
  logic [1:0]    hwy_l, cntry_l;

  // Reset wins over a tick landing in the same cycle.
  assign tick = !clr && (div_q == DIV_END);
  assign el   = {1'b0, cnt_q} + (TW+1)'(1);

  always_comb begin
    div_d = (div_q == DIV_END) ? '0 : div_q + DW'(1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    if (tick) begin
      unique case (state_q)
        HG: begin
          if (io.flash || (io.x && el >= HMIN_L))
            state_d = HY;
        end
        HY: begin
          if (el == YEL_L)
            state_d = AR1;
        end
        AR1: begin
          if (el == AR_L)
            state_d = io.flash ? FLASH : CG;
        end
        CG: begin
          if (io.flash || !io.x || el == CMAX_L)
            state_d = CY;
        end
        CY: begin
          if (el == YEL_L)
            state_d = AR2;
        end
        AR2: begin
          if (el == AR_L)
            state_d = io.flash ? FLASH : HG;
        end
        FLASH: begin
          if (!io.flash)
            state_d = AR2;
        end
        default: state_d = HG;
      endcase
      if (state_d != state_q) begin
        cnt_d = '0;
        ph_d  = (state_d == FLASH);
      end else begin
        // Saturate so a long highway green never wraps back below HWY_MIN.
        cnt_d = (&cnt_q) ? cnt_q : el[TW-1:0];
        if (state_q == FLASH)
          ph_d = !ph_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= HG;
      cnt_q   <= '0;
      div_q   <= '0;
      ph_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      ph_q    <= ph_d;
    end
  end

  always_comb begin
    hwy_l   = L_RED;
    cntry_l = L_RED;
    unique case (state_q)
      HG:  hwy_l   = L_GRN;
      HY:  hwy_l   = L_YEL;
      CG:  cntry_l = L_GRN;
      CY:  cntry_l = L_YEL;
      FLASH: begin
        if (ph_q) begin
          hwy_l = L_YEL;
        end else begin
          hwy_l   = L_DARK;
          cntry_l = L_DARK;
        end
      end
      default: begin
        hwy_l   = L_RED;
        cntry_l = L_RED;
      end
    endcase
  end

  assign io.hwy     = hwy_l;
  assign io.cntry   = cntry_l;
  assign io.tick    = tick;
  assign io.state_o = state_q;

endmodule
